line_clear_ctrl: RTL
====================

// Module: line_clear_ctrl
// PURPOSE
//  Playfield line-clear sequencer; sits directly downstream of the memcell array.
//  - Consumes the per-cell occupancy flags and, after a piece locks, finds full rows.
//  - Drives the per-row shift-down strobes back into the cells to delete each full row.
//  - Reports how many lines were removed, for scoring.
// PARAMETERS
//  WIDTH   10  columns per row
//  HEIGHT  20  rows; row 0 = top, row HEIGHT-1 = bottom
//  CW      $clog2(HEIGHT+1)  width of lines_cleared (derived, localparam)
// PORTS
//  clk            in   1             clock
//  reset          in   1             synchronous, active-low
//  start          in   1             1-cycle request to run a clear pass (piece just locked)
//  cell_occ       in   WIDTH*HEIGHT  bit r*WIDTH+c = cell (row r, col c) occupied
//  advance        out  HEIGHT        bit r = row r loads the row above it (row 0's source is tied to 0 outside)
//  busy           out  1             pass in progress; the integrator must not issue cell writes while high
//  done           out  1             1-cycle pulse at end of pass
//  lines_cleared  out  CW            rows removed in last pass; held until next accepted start
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//  - state=IDLE; advance=0, busy=0, done=0, lines_cleared=0.
//  - Applies even mid-pass: the advance strobe drops on the next edge and no done pulse follows.
//  Registered outputs: all outputs are registered. busy=1 in every state except IDLE.
//  FSM:
//  - IDLE:  start=1 -> SCAN; clear the internal count. start is ignored in every other state.
//  - SCAN (1 cycle):
//    - full[r] = &cell_occ[r*WIDTH +: WIDTH].
//    - k = highest-index r with full[r]=1.
//    - If no full row, or count==HEIGHT (guard) -> DONE.
//    - Else -> SHIFT; register advance[r]=1 for all r<=k, 0 above k; count+1.
//  - SHIFT (1 cycle):
//    - advance mask is visible for exactly this cycle.
//    - The cells shift on the closing edge, where advance returns to 0 -> SCAN.
//  - DONE (1 cycle): done=1, lines_cleared<=count -> IDLE.
//  Timing: no settle cycle is needed. Cell outputs are registered, so the SCAN that follows a SHIFT sees the shifted board.
//  Stacked full rows: when the row moved into k is itself full, it is re-detected at the same k on the next SCAN.
//  Pass length: n cleared rows = (n+1) SCAN + n SHIFT + 1 DONE cycles; start to done = 2n+2 edges.
//  Count: saturates at HEIGHT; pass terminates at most HEIGHT shifts.
//  Partial rows: cell_occ rows with any 0 bit are never cleared, whatever their position.
//  cell_occ is sampled only in SCAN; changes in other states are ignored.
// TESTING (WIDTH=10, HEIGHT=20, bench models memcell array incl. row-0 zero fill)
//  1. Empty board, start -> no advance ever; done 2 cycles after start; lines_cleared=0; busy high 2 cycles.
//  2. Row 19 full only -> one SHIFT with advance=20'hFFFFF; lines_cleared=1; board empty afterwards.
//  3. Rows 16-19 full, row 15 = 10'h001 -> four SHIFTs, each advance=20'hFFFFF; lines_cleared=4; final row 19 = 10'h001.
//  4. Rows 10 and 19 full, row 15 partial:
//     - masks 20'hFFFFF then 20'h00FFF; lines_cleared=2.
//     - final: partial row at row 16, row 10 content gone.
//  5. Row 5 with 9/10 cells set, start -> no advance; lines_cleared=0.
//  6. Control corner cases:
//     - start pulsed during SHIFT -> ignored (single done).
//     - reset=0 during SHIFT -> next cycle advance=0, busy=0, no done.
//     - after release, start works normally.

Source files
------------

// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_ctrl
//  Description : Playfield line-clear sequencer. Finds full rows after a lock
//                and strobes per-row shift-down into the memcell array.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_clear_ctrl #(
    parameter  int WIDTH  = 10,
    parameter  int HEIGHT = 20,
    localparam int CW     = $clog2(HEIGHT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   cell_occ,
    output logic [HEIGHT-1:0]         advance,
    output logic                      busy,
    output logic                      done,
    output logic [CW-1:0]             lines_cleared
);

    localparam int KW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] c_count_max = CW'(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [HEIGHT-1:0]   r_advance;
    logic                r_busy;
    logic                r_done;
    logic [CW-1:0]       r_lines;
    logic [CW-1:0]       r_count;

    logic [HEIGHT-1:0]   w_full;
    logic [HEIGHT-1:0]   w_mask;
    logic                w_found;
    logic [KW-1:0]       w_k;

    generate
        for (genvar r = 0; r < HEIGHT; r++) begin : g_row
            assign w_full[r] = &cell_occ[r*WIDTH +: WIDTH];
            // Every row at or above the lowest full row pulls from the row above it.
            assign w_mask[r] = (KW'(r) <= w_k);
        end
    endgenerate

    // Lowest full row on screen = highest row index; later matches win.
    always_comb begin
        w_found = 1'b0;
        w_k     = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (w_full[r]) begin
                w_found = 1'b1;
                w_k     = KW'(r);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_advance <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lines   <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end
                end
                S_SCAN: begin
                    if (!w_found || (r_count == c_count_max)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_lines <= r_count;
                    end else begin
                        r_state   <= S_SHIFT;
                        r_advance <= w_mask;
                        r_count   <= r_count + CW'(1);
                    end
                end
                S_SHIFT: begin
                    // Cells move on this closing edge; the next SCAN sees the new board.
                    r_state   <= S_SCAN;
                    r_advance <= '0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_advance <= '0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign advance       = r_advance;
    assign busy          = r_busy;
    assign done          = r_done;
    assign lines_cleared = r_lines;

endmodule
`default_nettype wire
